// File: rtl/lc3_mem_access_if.sv
// Data-memory bus between the LC3 memory-access stage and data memory.
// Request side holds Data_req/rd/addr/din steady until a one-cycle Data_ack.
// Data_rdata is only meaningful in the Data_ack cycle of a read.
interface lc3_mem_access_if;
  logic        Data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic        Data_ack;
  logic [15:0] Data_rdata;

  modport master (
    output Data_req, Data_rd, Data_addr, Data_din,
    input  Data_ack, Data_rdata
  );

  modport slave (
    input  Data_req, Data_rd, Data_addr, Data_din,
    output Data_ack, Data_rdata
  );
endinterface

// File: rtl/lc3_mem_access.sv
// Purpose: LC3 memory-access responder: read, indirect-pointer read or write per mem_state.
// Latency: Data_req one cycle after mem_state; complete_data two cycles after Data_ack.
// Backpressure: waits on Data_ack indefinitely, or aborts after TIMEOUT request cycles.
module lc3_mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mem_state,
  input  logic             new_instr,
  input  logic [15:0]      M_Addr,
  input  logic [15:0]      M_Data,
  output logic             complete_data,
  output logic             mem_err,
  output logic [15:0]      Data_dout,
  lc3_mem_access_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] TMO = TIMEOUT[15:0];

  state_t      state_q, state_d;
  logic        served_q, served_d;
  logic [1:0]  cap_state_q, cap_state_d;
  logic        ind_valid_q, ind_valid_d;
  logic [15:0] ind_ptr_q, ind_ptr_d;
  logic        req_q, req_d;
  logic        rd_q, rd_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [15:0] dout_q, dout_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        served_clr;

  // Any code change, idle code or new instruction re-arms the stage for another access.
  assign served_clr = (mem_state != cap_state_q) || (mem_state == 2'd3) || new_instr;

  // Next-state and registered-output logic for the IDLE/REQ/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    served_d    = served_q;
    cap_state_d = cap_state_q;
    ind_valid_d = ind_valid_q;
    ind_ptr_d   = ind_ptr_q;
    req_d       = req_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    din_d       = din_q;
    dout_d      = dout_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (mem_state == 2'd3) begin
          ind_valid_d = 1'b0;
        end
        // Use the already-cleared view of served so an LDI second access issues
        // one cycle after the controller switches code.
        if ((mem_state != 2'd3) && !(served_q && !served_clr)) begin
          state_d     = REQ;
          cap_state_d = mem_state;
          addr_d      = (ind_valid_q && (mem_state != 2'd1)) ? ind_ptr_q : M_Addr;
          din_d       = M_Data;
          rd_d        = (mem_state != 2'd2);
          req_d       = 1'b1;
          cnt_d       = '0;
        end
      end
      REQ: begin
        if (mem.Data_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (rd_q) begin
            dout_d = mem.Data_rdata;
          end
          if (cap_state_q == 2'd1) begin
            ind_ptr_d   = mem.Data_rdata;
            ind_valid_d = 1'b1;
          end else if (ind_valid_q) begin
            ind_valid_d = 1'b0;
          end
        end else if ((TIMEOUT != 0) && ((cnt_q + 16'd1) == TMO)) begin
          // Abort so the pipeline never hangs on a dead memory.
          req_d   = 1'b0;
          err_d   = 1'b1;
          dout_d  = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        served_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clears take priority over the DONE set.
    if (served_clr) begin
      served_d = 1'b0;
    end
    if (new_instr) begin
      ind_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops the request immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      served_q    <= 1'b0;
      cap_state_q <= 2'd3;
      ind_valid_q <= 1'b0;
      ind_ptr_q   <= '0;
      req_q       <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      dout_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      served_q    <= served_d;
      cap_state_q <= cap_state_d;
      ind_valid_q <= ind_valid_d;
      ind_ptr_q   <= ind_ptr_d;
      req_q       <= req_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign complete_data = served_q && (mem_state == cap_state_q);
  assign mem_err       = err_q;
  assign Data_dout     = dout_q;
  assign mem.Data_req  = req_q;
  assign mem.Data_rd   = rd_q;
  assign mem.Data_addr = addr_q;
  assign mem.Data_din  = din_q;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Bench for lc3_mem_access: directed LD/ST/LDI/STI, random instruction mix,
// timeout abort, stray ack and asynchronous reset during a request.
module tb_lc3_mem_access;

  localparam int TMO_CYC = 4;

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic [15:0] din;
    int          len;
    bit          stable;
  } txn_t;

  logic        clk;
  logic        rst;
  logic [1:0]  mem_state;
  logic        new_instr;
  logic [15:0] M_Addr;
  logic [15:0] M_Data;
  logic        complete_data;
  logic        mem_err;
  logic [15:0] Data_dout;

  lc3_mem_access_if bus ();

  lc3_mem_access #(.TIMEOUT(TMO_CYC)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_state     (mem_state),
    .new_instr     (new_instr),
    .M_Addr        (M_Addr),
    .M_Data        (M_Data),
    .complete_data (complete_data),
    .mem_err       (mem_err),
    .Data_dout     (Data_dout),
    .mem           (bus)
  );

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  txn_t        txq[$];
  txn_t        cur;
  int          run;
  int          lat_cfg;
  bit          stray;
  int          cyc;
  int          checks;
  int          errors;
  int          op_id;
  logic [15:0] dm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks on the lat_cfg-th request cycle (0 = never) and logs each request window.
  initial begin
    bus.Data_ack   = 1'b0;
    bus.Data_rdata = '0;
    run            = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.Data_ack = 1'b0;
      if (stray) begin
        bus.Data_ack   = 1'b1;
        bus.Data_rdata = 16'hDEAD;
      end else if (bus.Data_req === 1'b1) begin
        run++;
        if (run == 1) begin
          cur.addr   = bus.Data_addr;
          cur.rd     = bus.Data_rd;
          cur.din    = bus.Data_din;
          cur.stable = 1'b1;
        end else if (cur.addr !== bus.Data_addr || cur.rd !== bus.Data_rd || cur.din !== bus.Data_din) begin
          cur.stable = 1'b0;
        end
        if (run == lat_cfg) begin
          bus.Data_ack = 1'b1;
          if (bus.Data_rd) begin
            bus.Data_rdata = mem[bus.Data_addr];
          end else begin
            mem[bus.Data_addr] = bus.Data_din;
            bus.Data_rdata     = 16'($urandom);
          end
        end
      end else if (run > 0) begin
        cur.len = run;
        txq.push_back(cur);
        run = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s op%0d observed=%0h expected=%0h", tag, op_id, obs, exp);
    end
  endtask

  // Wait for complete_data, then check timing, the logged bus transaction and the read data.
  task automatic await_txn(input int k, input int latx, input logic [15:0] exp_addr,
                           input logic exp_rd, input logic [15:0] exp_din, input logic [15:0] exp_dout);
    bit   seen;
    txn_t t;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (complete_data === 1'b1) seen = 1'b1;
    end
    chk("complete_seen", seen, 1);
    chk("complete_cycle", cyc, k + 2 + latx);
    chk("txn_count", txq.size(), 1);
    if (txq.size() > 0) begin
      t = txq.pop_front();
      chk("txn_addr", t.addr, exp_addr);
      chk("txn_rd", t.rd, exp_rd);
      chk("txn_din", t.din, exp_din);
      chk("txn_req_cycles", t.len, latx);
      chk("txn_stable", t.stable, 1);
    end
    txq.delete();
    chk("dout", Data_dout, exp_dout);
    dm = exp_dout;
  endtask

  // One controller phase: present code (optionally with new_instr) and check the resulting access.
  task automatic step(input logic [1:0] code, input logic ni, input logic [15:0] a, input logic [15:0] d,
                      input int lat, input logic [15:0] exp_addr, input logic [15:0] exp_dout);
    int k;
    op_id++;
    @(posedge clk);
    #1;
    mem_state = code;
    new_instr = ni;
    M_Addr    = a;
    M_Data    = d;
    lat_cfg   = lat;
    k         = cyc;
    @(posedge clk);
    #1;
    new_instr = 1'b0;
    await_txn(k, (lat == 0) ? TMO_CYC : lat, exp_addr, code != 2'd2, d, exp_dout);
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    mem_state = 2'd3;
    @(negedge clk);
    chk("idle_complete_low", complete_data, 0);
  endtask

  initial begin
    logic [15:0] a, d, ptr;
    int          kind, lat, lat2, k;
    checks    = 0;
    errors    = 0;
    op_id     = 0;
    dm        = '0;
    rst       = 1'b1;
    mem_state = 2'd3;
    new_instr = 1'b0;
    M_Addr    = '0;
    M_Data    = '0;
    lat_cfg   = 1;
    stray     = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'((i * 40503) ^ 23130);
      ref_mem[i] = 16'((i * 40503) ^ 23130);
    end
    mem[16'h3000] = 16'hBEEF;  ref_mem[16'h3000] = 16'hBEEF;
    mem[16'h3002] = 16'h5000;  ref_mem[16'h3002] = 16'h5000;
    mem[16'h5000] = 16'h00AA;  ref_mem[16'h5000] = 16'h00AA;

    #1 rst = 1'b0;
    #2;
    chk("rst_complete", complete_data, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_dout", Data_dout, 0);
    chk("rst_req", bus.Data_req, 0);
    chk("rst_rd", bus.Data_rd, 0);
    chk("rst_addr", bus.Data_addr, 0);
    chk("rst_din", bus.Data_din, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Direct load with 3-cycle memory, complete held until idle code.
    step(2'd0, 1'b1, 16'h3000, 16'h0000, 3, 16'h3000, 16'hBEEF);
    repeat (3) begin
      @(negedge clk);
      chk("ld_complete_held", complete_data, 1);
    end
    go_idle();

    // Store with 1-cycle memory.
    step(2'd2, 1'b1, 16'h4010, 16'h1234, 1, 16'h4010, dm);
    ref_mem[16'h4010] = 16'h1234;
    chk("st_mem", mem[16'h4010], 16'h1234);
    go_idle();

    // LDI: pointer read then data read through the pointer.
    step(2'd1, 1'b1, 16'h3002, 16'h0000, 1, 16'h3002, 16'h5000);
    step(2'd0, 1'b0, 16'h3002, 16'h0000, 1, 16'h5000, 16'h00AA);
    go_idle();

    // STI: pointer read then write through the pointer, then a plain load must use M_Addr.
    step(2'd1, 1'b1, 16'h3002, 16'h7777, 2, 16'h3002, 16'h5000);
    step(2'd2, 1'b0, 16'h3002, 16'h7777, 1, 16'h5000, 16'h5000);
    ref_mem[16'h5000] = 16'h7777;
    chk("sti_mem", mem[16'h5000], 16'h7777);
    step(2'd0, 1'b1, 16'h3002, 16'h0000, 1, 16'h3002, 16'h5000);

    // Back-to-back loads with code held at 0.
    step(2'd0, 1'b1, 16'h0100, 16'h0000, 2, 16'h0100, ref_mem[16'h0100]);
    step(2'd0, 1'b1, 16'h0200, 16'h0000, 1, 16'h0200, ref_mem[16'h0200]);
    go_idle();

    // Random instruction mix against the memory model.
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 3));
      a    = 16'($urandom);
      d    = 16'($urandom);
      lat  = int'($urandom_range(1, TMO_CYC));
      lat2 = int'($urandom_range(1, TMO_CYC));
      case (kind)
        0: step(2'd0, 1'b1, a, d, lat, a, ref_mem[a]);
        1: begin
          step(2'd2, 1'b1, a, d, lat, a, dm);
          ref_mem[a] = d;
        end
        2: begin
          ptr = ref_mem[a];
          step(2'd1, 1'b1, a, d, lat, a, ptr);
          step(2'd0, 1'b0, a, d, lat2, ptr, ref_mem[ptr]);
        end
        default: begin
          ptr = ref_mem[a];
          step(2'd1, 1'b1, a, d, lat, a, ptr);
          step(2'd2, 1'b0, a, d, lat2, ptr, ptr);
          ref_mem[ptr] = d;
        end
      endcase
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();

    // Timeout: memory never acks.
    chk("err_before_tmo", mem_err, 0);
    step(2'd0, 1'b1, 16'h2222, 16'h0000, 0, 16'h2222, 16'h0000);
    chk("tmo_err", mem_err, 1);
    go_idle();

    // Stray ack while idle is ignored.
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_dout", Data_dout, 0);
    chk("stray_req", bus.Data_req, 0);
    chk("stray_complete", complete_data, 0);
    chk("stray_err", mem_err, 1);
    chk("stray_txn", txq.size(), 0);

    // Asynchronous reset in the middle of a request.
    op_id++;
    @(posedge clk);
    #1;
    mem_state = 2'd0;
    new_instr = 1'b1;
    M_Addr    = 16'h6060;
    M_Data    = 16'h0F0F;
    lat_cfg   = 0;
    @(posedge clk);
    #1;
    new_instr = 1'b0;
    chk("rstreq_req_before", bus.Data_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("rstreq_req", bus.Data_req, 0);
    chk("rstreq_rd", bus.Data_rd, 0);
    chk("rstreq_addr", bus.Data_addr, 0);
    chk("rstreq_din", bus.Data_din, 0);
    chk("rstreq_dout", Data_dout, 0);
    chk("rstreq_err", mem_err, 0);
    chk("rstreq_complete", complete_data, 0);
    @(negedge clk);
    @(negedge clk);
    txq.delete();
    lat_cfg = 2;
    @(posedge clk);
    #1;
    rst = 1'b1;
    k   = cyc;
    await_txn(k, 2, 16'h6060, 1'b1, 16'h0F0F, ref_mem[16'h6060]);
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_mem_access.md
# lc3_mem_access

Memory-access stage responder for the LC3 pipeline. It consumes the `mem_state` code driven by the pipeline controller and runs the matching data-memory transaction: direct read, indirect-pointer read, or write. It talks to data memory over a req/ack handshake with variable latency. When the access finishes it returns `complete_data` and the read data to the controller and writeback.

## Interface
Parameters:
- TIMEOUT, 255, max cycles `Data_req` waits for `Data_ack` before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_state  in  2  0=read, 1=indirect pointer read, 2=write, 3=idle
- new_instr  in  1  one-cycle pulse when a new instruction enters execute
- M_Addr  in  16  effective address from execute
- M_Data  in  16  store data from execute
- complete_data  out  1  access served; level signal
- mem_err  out  1  sticky timeout flag
- Data_dout  out  16  last read result (load data or pointer)
- Data_req  out  1  memory request
- Data_rd  out  1  1=read, 0=write; valid while `Data_req`=1
- Data_addr  out  16  memory address
- Data_din  out  16  write data
- Data_ack  in  1  memory acknowledge, one cycle
- Data_rdata  in  16  read data, valid in the `Data_ack` cycle

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE -> REQ** when `mem_state`!=3 and `served`=0.
  - Capture `cap_state`=`mem_state`.
  - Data_addr = ind_ptr if (`ind_valid` and `mem_state`∈{0,2}), else M_Addr.
  - Data_din = M_Data.
  - Data_rd = (`mem_state`!=2).
- **REQ:** hold `Data_req`, `Data_rd`, `Data_addr`, `Data_din` stable until `Data_ack`=1.
  - On ack, a read loads `Data_dout` from `Data_rdata`.
  - If `cap_state`=1: ind_ptr<=Data_rdata, ind_valid<=1.
  - If `cap_state`∈{0,2} and `ind_valid`: ind_valid<=0.
  - Next state DONE.
- **DONE:** `served`<=1. `complete_data`=1 while `served`=1 and `mem_state`==`cap_state`. Return to IDLE.
- **served clear:** on any cycle where `mem_state`!=`cap_state`, `mem_state`==3, or `new_instr`=1.
  - This lets an indirect sequence (1 then 0/2) issue its second access without passing through idle.
  - It also lets back-to-back same-code loads/stores each issue.
- **ind_valid clear:** on `new_instr`, or when `mem_state`==3 while in IDLE.
- **mem_state change during REQ:** the transaction is not withdrawn.
  - It completes and updates `Data_dout`/ind_ptr normally.
  - `complete_data` is suppressed (the code no longer matches).
  - The FSM then serves the new code.
- **Timeout:** a 16-bit wait counter runs in REQ. If TIMEOUT!=0 and the count reaches TIMEOUT with no ack:
  - `Data_req` drops and `mem_err`<=1 (cleared only by reset).
  - `Data_dout`<=16'h0000.
  - Go to DONE so the pipeline is not hung.
- A late `Data_ack` outside REQ is ignored.
- **Reset (asserted):** all outputs 0, FSM IDLE, `served`=0, `ind_valid`=0, ind_ptr=0, `cap_state`=3, counter 0.
  - Reset mid-REQ drops `Data_req` immediately, since reset is asynchronous.

## Timing
- All outputs are registered except `complete_data`, which is the AND of the registered `served` with the combinational `cap_state` compare.
- `mem_state` valid in cycle t gives `Data_req`=1 in t+1.
- `Data_ack` in cycle a gives `Data_req`=0 and `Data_dout` updated in a+1.
  - DONE occupies a+1; `served`=1 and `complete_data`=1 from a+2.
- Minimum turnaround (ack in the first `Data_req` cycle): `complete_data` at t+3.
- Indirect LDI with 1-cycle memory:
  - pointer `complete_data` at t+3;
  - controller switches to 0 at t+3 or later; second `Data_req` one cycle after the switch.
- `new_instr` coinciding with a DONE cycle: the clear wins, and `served` stays 0.
- Timeout abort: `Data_req` falls on cycle t+1+TIMEOUT.

## Test plan
- **Direct load:** mem_state=0, M_Addr=16'h3000, memory returns 16'hBEEF after 3 cycles.
  - Data_addr=3000, Data_rd=1, Data_req high 3 cycles.
  - Data_dout=BEEF, complete_data held until mem_state=3.
- **Store:** mem_state=2, M_Addr=16'h4010, M_Data=16'h1234, ack after 1 cycle.
  - Data_rd=0, Data_din=1234, complete_data at t+3.
- **LDI:** mem_state=1 at M_Addr=16'h3002 (memory holds 16'h5000), then 0; memory[5000]=16'h00AA.
  - Second access at Data_addr=5000, Data_dout=00AA, ind_valid cleared.
  - The same flow with state 2 writes M_Data to 5000.
- **Back-to-back loads:** two loads with mem_state held 0, new_instr pulse between.
  - Two separate Data_req windows, second at the new M_Addr.
- **Timeout:** TIMEOUT=4, never ack.
  - Data_req drops after 4 cycles, mem_err=1, Data_dout=0, complete_data=1.
  - A later stray ack is ignored.
- **Reset mid-REQ:** rst low while Data_req=1.
  - All outputs 0 immediately.
  - After release with mem_state=0 a fresh request issues.
